msi_cpu_fsm: RTL and testbench

Processor-side coherence controller for one cache block in the MSI snooping cache. It takes CPU read/write requests, decides hit or miss from the stored tag and coherence state, and issues the matching bus message using the shared 2-bit encoding: readMiss, invalidate, writeMiss. Before a miss that replaces an exclusive block, it writes that block back to memory. It sits between the CPU port and the bus arbiter, alongside the snoop-side coherence FSM that reacts to those same messages.

---
 rtl/msi_pkg.sv | 65 ++++++
 rtl/msi_cpu_fsm.sv | 123 ++++++++++++
 tb/tb_msi_cpu_fsm.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msi_pkg.sv
// Encodings shared by the CPU-side and snoop-side MSI coherence controllers.
// Also holds the CPU-side request decode so both views of the protocol stay in one place.
package msi_pkg;

  typedef enum logic [1:0] {
    MsgReadMiss   = 2'b00,
    MsgInvalidate = 2'b01,
    MsgWriteMiss  = 2'b10
  } bus_msg_e;

  typedef enum logic [1:0] {
    CohInvalid   = 2'b00,
    CohExclusive = 2'b01,
    CohShared    = 2'b10
  } coh_state_e;

  typedef enum logic [1:0] {
    PhIdle,
    PhWb,
    PhReq,
    PhDone
  } phase_e;

  typedef struct packed {
    logic       wb;
    logic       bus;
    bus_msg_e   msg;
    coh_state_e next_state;
  } action_t;

  localparam action_t ActionNone = '{
    wb:         1'b0,
    bus:        1'b0,
    msg:        MsgReadMiss,
    next_state: CohInvalid
  };

  // Defaults describe a plain miss; only shared and exclusive refine it.
  function automatic action_t decode_action(coh_state_e st, logic hit, logic write);
    action_t a;
    a.wb         = 1'b0;
    a.bus        = 1'b1;
    a.msg        = write ? MsgWriteMiss : MsgReadMiss;
    a.next_state = write ? CohExclusive : CohShared;
    case (st)
      CohShared: begin
        if (hit) begin
          if (write) a.msg = MsgInvalidate;
          else       a.bus = 1'b0;
        end
      end
      CohExclusive: begin
        if (hit) begin
          a.bus        = 1'b0;
          a.next_state = CohExclusive;
        end else begin
          a.wb = 1'b1;
        end
      end
      default: ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/msi_cpu_fsm.sv
// CPU-side MSI controller for one cache block: hit/miss decode, optional write-back of an
// exclusive victim, then the bus message; state and tag commit only on entry to DONE.
module msi_cpu_fsm
  import msi_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_valid,
  input  logic             cpu_write,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_ready,
  output logic             cpu_done,
  output logic             cpu_hit,
  output logic             bus_req,
  output logic [1:0]       bus_msg,
  output logic [TAG_W-1:0] bus_tag,
  output logic             wb_req,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             bus_grant,
  output logic [1:0]       state
);

  phase_e             phase_q, phase_d;
  action_t            act_q, act_d, act_dec;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  coh_state_e         state_q;
  logic [TAG_W-1:0]   tag_q;
  logic               hit;
  logic               commit;

  logic               cpu_done_q, cpu_done_d;
  logic               cpu_hit_q, cpu_hit_d;
  logic               bus_req_q, bus_req_d;
  bus_msg_e           bus_msg_q, bus_msg_d;
  logic [TAG_W-1:0]   bus_tag_q, bus_tag_d;
  logic               wb_req_q, wb_req_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;

  assign cpu_ready = (phase_q == PhIdle);
  assign hit       = (state_q != CohInvalid) && (cpu_tag == tag_q);
  assign act_dec   = decode_action(state_q, hit, cpu_write);

  always_comb begin
    phase_d   = phase_q;
    act_d     = act_q;
    req_tag_d = req_tag_q;
    unique case (phase_q)
      PhIdle: begin
        if (cpu_valid) begin
          act_d     = act_dec;
          req_tag_d = cpu_tag;
          if (act_dec.wb)       phase_d = PhWb;
          else if (act_dec.bus) phase_d = PhReq;
          else                  phase_d = PhDone;
        end
      end
      PhWb:    if (bus_grant) phase_d = PhReq;
      PhReq:   if (bus_grant) phase_d = PhDone;
      PhDone:  phase_d = PhIdle;
      default: phase_d = PhIdle;
    endcase
  end

  // Registered outputs are decoded from the next phase so they line up with it.
  always_comb begin
    commit     = (phase_d == PhDone) && (phase_q != PhDone);
    cpu_done_d = commit;
    cpu_hit_d  = commit && !act_d.bus;
    wb_req_d   = (phase_d == PhWb);
    wb_tag_d   = wb_req_d ? tag_q : '0;
    bus_req_d  = (phase_d == PhReq);
    bus_msg_d  = bus_req_d ? act_d.msg : MsgReadMiss;
    bus_tag_d  = bus_req_d ? req_tag_d : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= PhIdle;
      act_q      <= ActionNone;
      req_tag_q  <= '0;
      cpu_done_q <= 1'b0;
      cpu_hit_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_msg_q  <= MsgReadMiss;
      bus_tag_q  <= '0;
      wb_req_q   <= 1'b0;
      wb_tag_q   <= '0;
    end else begin
      phase_q    <= phase_d;
      act_q      <= act_d;
      req_tag_q  <= req_tag_d;
      cpu_done_q <= cpu_done_d;
      cpu_hit_q  <= cpu_hit_d;
      bus_req_q  <= bus_req_d;
      bus_msg_q  <= bus_msg_d;
      bus_tag_q  <= bus_tag_d;
      wb_req_q   <= wb_req_d;
      wb_tag_q   <= wb_tag_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CohInvalid;
      tag_q   <= '0;
    end else if (commit) begin
      state_q <= act_d.next_state;
      tag_q   <= req_tag_d;
    end
  end

  assign cpu_done = cpu_done_q;
  assign cpu_hit  = cpu_hit_q;
  assign bus_req  = bus_req_q;
  assign bus_msg  = bus_msg_q;
  assign bus_tag  = bus_tag_q;
  assign wb_req   = wb_req_q;
  assign wb_tag   = wb_tag_q;
  assign state    = state_q;

endmodule

// File: tb/tb_msi_cpu_fsm.sv
// Bench for msi_cpu_fsm: table of requests with hand-written expectations, scoreboard queues
// popped by a negedge monitor, plus a reset-abort sequence.
module tb_msi_cpu_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_valid = 1'b0;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_tag = '0;
  logic       cpu_ready, cpu_done, cpu_hit;
  logic       bus_req, wb_req;
  logic [1:0] bus_msg, state;
  logic [7:0] bus_tag, wb_tag;
  logic       bus_grant;

  msi_cpu_fsm #(.TAG_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_write (cpu_write),
    .cpu_tag   (cpu_tag),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .bus_req   (bus_req),
    .bus_msg   (bus_msg),
    .bus_tag   (bus_tag),
    .wb_req    (wb_req),
    .wb_tag    (wb_tag),
    .bus_grant (bus_grant),
    .state     (state)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    bit       pre_reset;
    bit       write;
    bit [7:0] tag;
    bit [7:0] dly;
    bit       idle_grant;
    bit       noise;
    bit       exp_hit;
    bit       exp_wb;
    bit [7:0] exp_wb_tag;
    bit [1:0] exp_msg;
    bit [7:0] exp_bus_tag;
    bit [1:0] exp_state;
  } vec_t;

  typedef struct packed {
    logic [7:0] tag;
    logic [1:0] old_state;
  } wb_exp_t;

  typedef struct packed {
    logic [1:0] msg;
    logic [7:0] tag;
    logic [7:0] len;
    logic [1:0] old_state;
  } bus_exp_t;

  typedef struct packed {
    logic        hit;
    logic [1:0]  state;
    logic [31:0] cyc;
  } done_exp_t;

  wb_exp_t   wb_q[$];
  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int gdelay = 0;
  bit grant_idle = 1'b0;
  bit abort_len = 1'b0;
  logic [1:0] state_cur = 2'b00;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Grant after gdelay waiting cycles of each request phase; idle grant is noise.
  initial begin
    int wcnt;
    wcnt = 0;
    bus_grant = 1'b0;
    forever begin
      @(negedge clock);
      if (wb_req || bus_req) begin
        if (wcnt >= gdelay) begin
          bus_grant = 1'b1;
          wcnt = 0;
        end else begin
          bus_grant = 1'b0;
          wcnt++;
        end
      end else begin
        bus_grant = grant_idle;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops scoreboard entries as the DUT produces events.
  initial begin
    logic wb_prev, bus_prev, cur_ok;
    int blen;
    bus_exp_t cur_bus;
    wb_exp_t w;
    done_exp_t d;
    wb_prev = 1'b0;
    bus_prev = 1'b0;
    cur_ok = 1'b0;
    blen = 0;
    cur_bus = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (wb_req && !wb_prev) begin
          if (wb_q.size() == 0) check("unexpected_wb_req", 1, 0);
          else begin
            w = wb_q.pop_front();
            check("wb_tag", wb_tag, w.tag);
            check("state_during_wb", state, w.old_state);
          end
        end
        if (bus_req) begin
          if (!bus_prev) begin
            blen = 0;
            if (bus_q.size() == 0) begin
              check("unexpected_bus_req", 1, 0);
              cur_ok = 1'b0;
            end else begin
              cur_bus = bus_q.pop_front();
              cur_ok = 1'b1;
              check("state_during_bus", state, cur_bus.old_state);
            end
          end
          blen++;
          if (cur_ok) check("bus_msg_tag", {bus_msg, bus_tag}, {cur_bus.msg, cur_bus.tag});
        end else if (bus_prev && cur_ok && !abort_len) begin
          check("bus_req_len", blen, cur_bus.len);
        end
        if (cpu_done) begin
          if (done_q.size() == 0) check("unexpected_cpu_done", 1, 0);
          else begin
            d = done_q.pop_front();
            check("cpu_hit", cpu_hit, d.hit);
            check("state_at_done", state, d.state);
            check("done_cycle", cyc, d.cyc);
          end
        end
      end
      wb_prev = wb_req;
      bus_prev = bus_req;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    cpu_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    state_cur = 2'b00;
  endtask

  task automatic wait_ready(output bit ok);
    int tmo;
    @(negedge clock);
    #1;
    tmo = 0;
    while (!cpu_ready && tmo < 100) begin
      @(negedge clock);
      #1;
      tmo++;
    end
    ok = cpu_ready;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat, tmo;
    bit ok;
    abort_len = 1'b0;
    if (v.pre_reset) do_reset();
    gdelay = int'(v.dly);
    grant_idle = v.idle_grant;
    wait_ready(ok);
    if (!ok) return;
    lat = v.exp_hit ? 1 : (v.exp_wb ? 2 * gdelay + 3 : gdelay + 2);
    if (v.exp_wb) wb_q.push_back('{tag: v.exp_wb_tag, old_state: state_cur});
    if (!v.exp_hit)
      bus_q.push_back('{msg: v.exp_msg, tag: v.exp_bus_tag, len: 8'(gdelay + 1),
                        old_state: state_cur});
    done_q.push_back('{hit: v.exp_hit, state: v.exp_state, cyc: 32'(cyc + lat)});
    cpu_valid = 1'b1;
    cpu_write = v.write;
    cpu_tag = v.tag;
    @(posedge clock);
    #1;
    if (v.noise) begin
      cpu_tag = ~v.tag;
      cpu_write = ~v.write;
    end else begin
      cpu_valid = 1'b0;
    end
    tmo = 0;
    while (done_q.size() != 0 && tmo < 200) begin
      @(negedge clock);
      #1;
      tmo++;
    end
    cpu_valid = 1'b0;
    if (done_q.size() != 0) begin
      check("done_timeout", 0, 1);
      wb_q.delete();
      bus_q.delete();
      done_q.delete();
    end
    state_cur = v.exp_state;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int tmo;
    // pre_reset, write, tag, dly, idle_grant, noise, hit, wb, wb_tag, msg, bus_tag, state
    vecs[0]  = '{0, 0, 8'h12, 0, 0, 0, 0, 0, 8'h00, 2'b00, 8'h12, 2'b10};
    vecs[1]  = '{0, 0, 8'h12, 0, 0, 1, 1, 0, 8'h00, 2'b00, 8'h00, 2'b10};
    vecs[2]  = '{0, 1, 8'h12, 3, 0, 0, 0, 0, 8'h00, 2'b01, 8'h12, 2'b01};
    vecs[3]  = '{0, 0, 8'h12, 1, 0, 1, 1, 0, 8'h00, 2'b00, 8'h00, 2'b01};
    vecs[4]  = '{0, 1, 8'h12, 0, 0, 0, 1, 0, 8'h00, 2'b00, 8'h00, 2'b01};
    vecs[5]  = '{0, 0, 8'h34, 0, 1, 0, 0, 1, 8'h12, 2'b00, 8'h34, 2'b10};
    vecs[6]  = '{0, 1, 8'h34, 2, 0, 1, 0, 0, 8'h00, 2'b01, 8'h34, 2'b01};
    vecs[7]  = '{0, 1, 8'h56, 1, 0, 0, 0, 1, 8'h34, 2'b10, 8'h56, 2'b01};
    vecs[8]  = '{0, 0, 8'h56, 0, 0, 0, 1, 0, 8'h00, 2'b00, 8'h00, 2'b01};
    vecs[9]  = '{0, 0, 8'h78, 0, 1, 1, 0, 1, 8'h56, 2'b00, 8'h78, 2'b10};
    vecs[10] = '{0, 0, 8'h9A, 2, 0, 0, 0, 0, 8'h00, 2'b00, 8'h9A, 2'b10};
    vecs[11] = '{0, 1, 8'hBC, 0, 0, 0, 0, 0, 8'h00, 2'b10, 8'hBC, 2'b01};
    vecs[12] = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 2'b00, 8'h00, 2'b10};
    vecs[13] = '{1, 1, 8'h12, 0, 0, 0, 0, 0, 8'h00, 2'b10, 8'h12, 2'b01};
    vecs[14] = '{0, 1, 8'h34, 0, 1, 0, 0, 1, 8'h12, 2'b10, 8'h34, 2'b01};
    vecs[15] = '{0, 0, 8'h34, 0, 0, 0, 1, 0, 8'h00, 2'b00, 8'h00, 2'b01};
    vecs[16] = '{0, 0, 8'h12, 0, 0, 0, 0, 1, 8'h34, 2'b00, 8'h12, 2'b10};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("reset_cpu_ready", cpu_ready, 1);
    check("reset_done_hit", {cpu_done, cpu_hit}, 0);
    check("reset_bus", {bus_req, bus_msg, bus_tag}, 0);
    check("reset_wb", {wb_req, wb_tag}, 0);
    check("reset_state", state, 0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Reset while a shared write miss waits for grant; busy-phase requests must be ignored.
    gdelay = 20;
    grant_idle = 1'b0;
    abort_len = 1'b0;
    wait_ready(ok);
    if (ok) begin
      bus_q.push_back('{msg: 2'b10, tag: 8'h77, len: 8'd21, old_state: state_cur});
      cpu_valid = 1'b1;
      cpu_write = 1'b1;
      cpu_tag = 8'h77;
      @(posedge clock);
      #1;
      cpu_tag = 8'h12;
      cpu_write = 1'b0;
      tmo = 0;
      while (!bus_req && tmo < 20) begin
        @(negedge clock);
        #1;
        tmo++;
      end
      check("abort_bus_req_seen", bus_req, 1);
      repeat (2) @(negedge clock);
      #1;
      abort_len = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("abort_bus_req", bus_req, 0);
      check("abort_wb_req", wb_req, 0);
      check("abort_state", state, 0);
      check("abort_cpu_ready", cpu_ready, 1);
      check("abort_cpu_done", cpu_done, 0);
      reset = 1'b0;
      cpu_valid = 1'b0;
      state_cur = 2'b00;
      gdelay = 0;
      repeat (3) @(negedge clock);
    end
    // Nothing committed by the aborted request: reading 0x12 is an invalid-state miss.
    run_vec('{0, 0, 8'h12, 0, 0, 0, 0, 0, 8'h00, 2'b00, 8'h12, 2'b10});

    repeat (3) @(negedge clock);
    check("queues_drained", wb_q.size() + bus_q.size() + done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
